// File: rtl/conv_pkg.sv
// ============================================================================
// conv_pkg : shared widths/sizes of the convolution path and the output
//            round / ReLU / saturate helper.
// Rev 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

   localparam int unsigned c_data_width_x = 8;
   localparam int unsigned c_data_width_f = 8;
   localparam int unsigned c_x_size       = 7;
   localparam int unsigned c_f_size       = 3;
   localparam int unsigned c_in_width     = c_data_width_x + c_data_width_f + 2;
   localparam int unsigned c_y_count      = c_x_size - c_f_size + 1;

   // Working width of the helper; must exceed any IN_WIDTH + 1 used with it.
   localparam int unsigned c_max_width    = 40;

   typedef struct packed {
      logic                          sat;
      logic signed [c_max_width-1:0] value;
   } sat_res_t;

   function automatic sat_res_t sat_round(
      input logic signed [c_max_width-1:0] x,
      input int unsigned                   shift,
      input int unsigned                   out_width,
      input logic                          relu_en
   );
      logic signed [c_max_width-1:0] r;
      logic signed [c_max_width-1:0] one;
      logic signed [c_max_width-1:0] hi;
      logic signed [c_max_width-1:0] lo;
      sat_res_t                      res;
      one = {{(c_max_width-1){1'b0}}, 1'b1};
      r   = x;
      if (shift > 0) begin
         r = (x + (one <<< (shift - 1))) >>> shift;
      end
      if (relu_en && r[c_max_width-1]) begin
         r = '0;
      end
      hi        = (one <<< (out_width - 1)) - one;
      lo        = -(one <<< (out_width - 1));
      res.sat   = 1'b0;
      res.value = r;
      if (r > hi) begin
         res.sat   = 1'b1;
         res.value = hi;
      end else if (r < lo) begin
         res.sat   = 1'b1;
         res.value = lo;
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO, no full-bypass, head entry shown on rd_data.
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int unsigned  c_aw   = $clog2(DEPTH);
   localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign full    = (r_count == c_full);
   assign empty   = (r_count == '0);
   assign w_push  = wr_en && !full;
   assign w_pop   = rd_en && !empty;
   assign rd_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/y_postproc.sv
// ============================================================================
// y_postproc : round/ReLU/saturate the conv accumulator stream, buffer it and
//              tag every Y_COUNT-th output as last.
// Rev 1.0
// ============================================================================
`default_nettype none

module y_postproc
   import conv_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = c_in_width,
   parameter int unsigned OUT_WIDTH = 8,
   parameter int unsigned SHIFT     = 4,
   parameter int unsigned RELU_EN   = 1,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned Y_COUNT   = c_y_count
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_valid_y,
   output logic                 s_ready_y,
   input  logic [IN_WIDTH-1:0]  s_data_in_y,
   output logic                 m_valid_z,
   input  logic                 m_ready_z,
   output logic [OUT_WIDTH-1:0] m_data_out_z,
   output logic                 m_last_z,
   output logic [7:0]           sat_count
);

   localparam int unsigned       c_idx_w    = (Y_COUNT > 1) ? $clog2(Y_COUNT) : 1;
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(Y_COUNT - 1);

   logic signed [c_max_width-1:0] w_ext;
   sat_res_t                      w_res;
   logic                          w_push;
   logic                          w_is_last;
   logic                          w_fifo_full;
   logic                          w_fifo_empty;
   logic [OUT_WIDTH:0]            w_head;
   logic                          w_unused;
   logic [c_idx_w-1:0]            r_index;
   logic [7:0]                    r_sat_count;

   assign w_ext     = {{(c_max_width - IN_WIDTH){s_data_in_y[IN_WIDTH-1]}}, s_data_in_y};
   assign w_res     = sat_round(w_ext, SHIFT, OUT_WIDTH, RELU_EN != 0);
   assign w_unused  = ^w_res.value[c_max_width-1:OUT_WIDTH];
   assign s_ready_y = !w_fifo_full;
   assign w_push    = s_valid_y && s_ready_y;
   assign w_is_last = (r_index == c_last_idx);

   sync_fifo #(
      .WIDTH (OUT_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_push),
      .wr_data ({w_is_last, w_res.value[OUT_WIDTH-1:0]}),
      .full    (w_fifo_full),
      .rd_en   (m_ready_z),
      .rd_data (w_head),
      .empty   (w_fifo_empty)
   );

   assign m_valid_z    = !w_fifo_empty;
   assign m_last_z     = w_head[OUT_WIDTH];
   assign m_data_out_z = w_head[OUT_WIDTH-1:0];
   assign sat_count    = r_sat_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_index     <= '0;
         r_sat_count <= '0;
      end else if (w_push) begin
         r_index <= w_is_last ? '0 : r_index + 1'b1;
         // Sticky at 255 rather than wrapping.
         if (w_res.sat && (r_sat_count != 8'hFF)) begin
            r_sat_count <= r_sat_count + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/y_postproc.md
# y_postproc

Output post-processing stage that sits directly downstream of the convolution core. It accepts the signed accumulator stream on a valid/ready handshake and applies round-half-up arithmetic right shift, optional ReLU, and saturation to OUT_WIDTH. Results are buffered in a small FIFO and emitted with a per-convolution last marker, so the core's `m_ready_y` is decoupled from the consumer's backpressure.

## Interface
- IN_WIDTH, 18: width of the signed input sample, equal to the core's DATA_WIDTH_X+DATA_WIDTH_F+2.
- OUT_WIDTH, 8: width of the signed output sample.
- SHIFT, 4: arithmetic right shift amount, 0..IN_WIDTH-1.
- RELU_EN, 1: 1 clamps negative values to 0.
- DEPTH, 4: FIFO entries, a power of 2 and at least 2.
- Y_COUNT, 5: outputs per convolution, X_SIZE-F_SIZE+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; all state clears while it is 0.
- s_valid_y  in  1  upstream sample valid.
- s_ready_y  out  1  block can accept a sample.
- s_data_in_y  in  IN_WIDTH  signed upstream sample.
- m_valid_z  out  1  output sample valid.
- m_ready_z  in  1  downstream accepts.
- m_data_out_z  out  OUT_WIDTH  signed processed sample.
- m_last_z  out  1  marks the Y_COUNT-th output of a convolution.
- sat_count  out  8  number of saturation events; stops counting at 255.

## Operation
- Handshake rules:
  - Input transfer occurs when s_valid_y && s_ready_y at a rising edge.
  - Output transfer occurs when m_valid_z && m_ready_z at a rising edge.
  - m_valid_z and data, once asserted, stay stable until the output transfer.
- Arithmetic is combinational on s_data_in_y and is applied at write time:
  - If SHIFT>0: r = (sext(s_data_in_y, IN_WIDTH+1) + 2^(SHIFT-1)) >>> SHIFT. If SHIFT=0: r = s_data_in_y.
  - If RELU_EN and r<0, r becomes 0. This is not a saturation event.
  - r is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. A clamp on an accepted sample increments sat_count by 1, stopping at 255.
- FIFO:
  - DEPTH entries of {last, data}, with write pointer, read pointer and occupancy count of width clog2(DEPTH)+1.
  - s_ready_y = (count != DEPTH), combinational from count only. There is no full-bypass: a pop while full does not allow a push in the same cycle.
  - m_valid_z = (count != 0). m_data_out_z and m_last_z are driven from the head entry.
  - Simultaneous push and pop (count strictly between 0 and DEPTH): both pointers advance and count is unchanged.
  - Pointers wrap modulo DEPTH.
- Last marker:
  - An index counter 0..Y_COUNT-1 advances on each input transfer and wraps to 0 after Y_COUNT-1.
  - The stored last bit equals (index == Y_COUNT-1) at write time.
- Reset while asserted:
  - Pointers, count, index and sat_count are 0; the storage array is 0.
  - m_valid_z=0, m_data_out_z=0, m_last_z=0, s_ready_y=1, sat_count=0.
  - Reset mid-stream discards buffered data and restarts the last-index at 0.

## Timing
- Latency with the FIFO empty: sample accepted at edge N appears with m_valid_z=1 immediately after edge N. That is one cycle, and it can be popped at edge N+1.
- Throughput is one sample per cycle in both directions when 0<count<DEPTH.
- When full: s_ready_y=0. A pop at edge N raises s_ready_y after edge N, so the next push is possible at edge N+1.
- When empty: m_valid_z=0 and m_ready_z is ignored. A push-only at edge N makes m_valid_z valid after N.
- sat_count updates at the same edge as the input transfer.

## Structure
- Shared package conv_pkg holds:
  - the `sat_round` function (shift, ReLU, clamp), with its widths passed as parameters;
  - localparam defaults for IN_WIDTH and Y_COUNT, matching the core's X_SIZE/F_SIZE.
- One sub-module: `sync_fifo` (WIDTH, DEPTH), containing pointers, count, full/empty and async active-low reset.
- The top level holds the arithmetic, the last-index counter and sat_count.

## Test plan
All cases use defaults: SHIFT=4, OUT_WIDTH=8, RELU_EN=1, DEPTH=4, Y_COUNT=5.
- Rounding: input 64 gives output 4; input 24 gives 2 (1.5 rounds up); input 8 gives 1; input 7 gives 0. sat_count stays 0.
- Saturation and ReLU:
  - Input 2047 gives 127 and sat_count becomes 1.
  - Input -100 gives 0 and sat_count is unchanged.
  - With RELU_EN=0, input -131072 gives -128 and sat_count increments.
- Backpressure:
  - Hold m_ready_z=0 and drive 5 samples. 4 are accepted and s_ready_y=0 after the 4th.
  - Raise m_ready_z. Outputs appear in order, and the 5th sample is accepted one cycle after the first pop.
- Last marker: stream 10 samples with m_ready_z=1. m_last_z=1 exactly on outputs 5 and 10, with one output per cycle after the first.
- Reset mid-operation:
  - With 3 entries buffered and index=3, pull reset low asynchronously.
  - m_valid_z drops immediately and sat_count returns to 0.
  - After release, the next 5 samples yield m_last_z on the 5th.
- sat_count stops at 255: 300 saturating samples leave sat_count=255.
